// File: rtl/pinwheel_uart_pkg.sv
// Shared types for the pinwheel UART transmitter: FSM state encoding and parity modes.
// Also provides the parity helper used when a byte is loaded into the shift register.
package pinwheel_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/pinwheel_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count; read data is the head entry.
// Push is ignored while full (even with a same-cycle pop), pop is ignored while empty.
module pinwheel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_vld,
  input  logic [WIDTH-1:0]        wr_dat,
  output logic                    wr_rdy,
  output logic                    rd_vld,
  input  logic                    rd_rdy,
  output logic [WIDTH-1:0]        rd_dat,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W:0]   count_nxt;

  assign do_push = wr_vld && !full;
  assign do_pop  = rd_rdy && !empty;
  assign wr_rdy  = !full;
  assign rd_vld  = !empty;
  assign rd_dat  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (PTR_W+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/pinwheel_uart_tx.sv
// UART transmitter with input FIFO and CTS flow control; tx falls 2 cycles after a byte is accepted when idle.
// in_ready drops when the FIFO is full; CTS is checked only at frame boundaries, so a frame always completes.
module pinwheel_uart_tx
  import pinwheel_uart_pkg::*;
#(
  parameter int CLOCK_RATE = 24_000_000,
  parameter int BAUD_RATE  = 1_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic [DATA_BITS-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           cts_n,
  output logic                           tx,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
  localparam int CLKS_PER_BIT = (BAUD_RATE > 0) ? (CLOCK_RATE / BAUD_RATE) : 0;
  localparam int CNT_W        = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_err_cpb
    $error("pinwheel_uart_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_err_data
    $error("pinwheel_uart_tx: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("pinwheel_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("pinwheel_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("pinwheel_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 cts_meta;
  logic                 cts_sync;
  uart_state_t          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 fifo_vld;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 pop;
  logic                 bit_done;
  logic                 last_stop;
  logic                 can_start;

  pinwheel_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (reset),
    .wr_vld (in_valid),
    .wr_dat (in_data),
    .wr_rdy (in_ready),
    .rd_vld (fifo_vld),
    .rd_rdy (pop),
    .rd_dat (fifo_dat),
    .count  (fifo_count)
  );

  // Synchroniser resets to "not clear to send" so nothing leaves before the pad is sampled.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign bit_done  = (baud_cnt == '0);
  assign last_stop = (state == ST_STOP) && bit_done && (bit_idx == STOP_LAST);
  assign can_start = fifo_vld && !cts_sync;
  assign pop       = can_start && ((state == ST_IDLE) || last_stop);

  // tx and busy are registered from the current state, so both trail the FSM by one cycle together.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE);
      case (state)
        ST_START:  tx <= 1'b0;
        ST_DATA:   tx <= shift_reg[0];
        ST_PARITY: tx <= par_bit;
        default:   tx <= 1'b1;
      endcase

      if (state != ST_IDLE && !bit_done) begin
        baud_cnt <= baud_cnt - CNT_W'(1);
      end else begin
        baud_cnt <= CNT_RELOAD;
      end

      if (pop) begin
        shift_reg <= fifo_dat;
        par_bit   <= parity_bit(8'(fifo_dat), PARITY);
        bit_idx   <= '0;
        state     <= ST_START;
      end else if (bit_done) begin
        case (state)
          ST_START: begin
            bit_idx <= '0;
            state   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 3'd1;
            end
          end
          ST_PARITY: begin
            bit_idx <= '0;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            if (last_stop) begin
              state <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pinwheel_uart_tx.sv
// Bench for pinwheel_uart_tx: three instances (8N1, 8E2, 8O1) at 8 clocks per bit, random bytes
// checked cycle by cycle against an expected bit sequence built from the framing rules.
module tb_pinwheel_uart_tx;
  import pinwheel_uart_pkg::*;

  localparam int CPB = 8;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       cts_n;

  logic       rdy_a, tx_a, busy_a;
  logic       rdy_b, tx_b, busy_b;
  logic       rdy_c, tx_c, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  int         sel;
  logic       rdy_s, tx_s, busy_s;
  logic [2:0] cnt_s;

  int n_assert = 0;
  int n_fail   = 0;
  int last_wait;
  logic [7:0] q[$];

  always #5 CLK = ~CLK;

  pinwheel_uart_tx #(.CLOCK_RATE(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
  dut_a (.CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
         .cts_n(cts_n), .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

  pinwheel_uart_tx #(.CLOCK_RATE(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
  dut_b (.CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
         .cts_n(cts_n), .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

  pinwheel_uart_tx #(.CLOCK_RATE(8), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
  dut_c (.CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_c),
         .cts_n(cts_n), .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));

  always_comb begin
    rdy_s  = rdy_a;
    tx_s   = tx_a;
    busy_s = busy_a;
    cnt_s  = cnt_a;
    case (sel)
      1: begin rdy_s = rdy_b; tx_s = tx_b; busy_s = busy_b; cnt_s = cnt_b; end
      2: begin rdy_s = rdy_c; tx_s = tx_c; busy_s = busy_c; cnt_s = cnt_c; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  // Returns at the first falling edge after the accepting rising edge.
  task automatic push(input logic [7:0] d);
    bit took;
    took = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !took; i++) begin
      took = rdy_s;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    chk("push_accepted", 32'(took), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int w;
    w = 0;
    while (tx_s !== 1'b0 && w < budget) begin
      @(negedge CLK);
      w++;
    end
    last_wait = w;
    chk({tag, "_start_seen"}, 32'(tx_s), 32'd0);
  endtask

  // Expected line: start 0, data LSB first, optional parity making the ones count odd/even, stop ones.
  task automatic check_frame(input logic [7:0] d, input int par, input int stops, input int cts_at);
    bit bits[$];
    int ones;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par == PARITY_EVEN) bits.push_back((ones % 2) == 1);
    else if (par == PARITY_ODD) bits.push_back((ones % 2) == 0);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b * CPB + c == cts_at) cts_n = 1'b1;
        chk($sformatf("tx_%02h_bit%0d_cyc%0d", d, b, c), 32'(tx_s), 32'(bits[b]));
        chk($sformatf("busy_%02h_bit%0d_cyc%0d", d, b, c), 32'(busy_s), 32'd1);
        @(negedge CLK);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_tx_idle"}, 32'(tx_s), 32'd1);
    chk({tag, "_busy_idle"}, 32'(busy_s), 32'd0);
    chk({tag, "_count_empty"}, 32'(cnt_s), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    sel = 0; reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; cts_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge CLK);

    // 8N1 0x55 with accept-to-start latency
    push(8'h55);
    chk("lat_tx_c0", 32'(tx_s), 32'd1);
    @(negedge CLK);
    chk("lat_tx_c1", 32'(tx_s), 32'd1);
    chk("lat_busy_c1", 32'(busy_s), 32'd0);
    @(negedge CLK);
    check_frame(8'h55, PARITY_NONE, 1, -1);
    expect_idle("t1");

    // random bursts of 1..3 bytes, sent back to back
    for (int k = 0; k < 5; k++) begin
      q.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        push(b);
      end
      wait_start("rand", 10);
      foreach (q[i]) check_frame(q[i], PARITY_NONE, 1, -1);
      expect_idle("rand");
    end

    // two bytes on consecutive cycles: no gap between frames
    push(8'hA5);
    push(8'h3C);
    wait_start("b2b", 10);
    check_frame(8'hA5, PARITY_NONE, 1, -1);
    check_frame(8'h3C, PARITY_NONE, 1, -1);
    expect_idle("b2b");

    // CTS held off: FIFO fills, fifth byte refused
    do_reset();
    cts_n = 1'b1;
    repeat (3) @(negedge CLK);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      push(b);
    end
    chk("full_count", 32'(cnt_s), 32'd4);
    chk("full_ready", 32'(rdy_s), 32'd0);
    in_data  = 8'hEE;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("full_refuse_ready", 32'(rdy_s), 32'd0);
      chk("full_tx_held", 32'(tx_s), 32'd1);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    chk("full_count_after", 32'(cnt_s), 32'd4);
    cts_n = 1'b0;
    wait_start("full", 10);
    foreach (q[i]) check_frame(q[i], PARITY_NONE, 1, -1);
    chk("drain_ready", 32'(rdy_s), 32'd1);
    expect_idle("drain");

    // even parity, two stop bits
    sel = 1;
    do_reset();
    push(8'h07);
    wait_start("even", 10);
    check_frame(8'h07, PARITY_EVEN, 2, -1);
    expect_idle("even");
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      push(b);
      wait_start("even_rand", 10);
      check_frame(b, PARITY_EVEN, 2, -1);
      expect_idle("even_rand");
    end

    // odd parity, one stop bit
    sel = 2;
    do_reset();
    push(8'h07);
    wait_start("odd", 10);
    check_frame(8'h07, PARITY_ODD, 1, -1);
    expect_idle("odd");
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      push(b);
      wait_start("odd_rand", 10);
      check_frame(b, PARITY_ODD, 1, -1);
      expect_idle("odd_rand");
    end

    // async reset in the middle of the data bits
    sel = 0;
    do_reset();
    push(8'($urandom));
    push(8'($urandom));
    wait_start("mid", 10);
    repeat (CPB + 2 * CPB + 3) @(negedge CLK);
    chk("mid_count", 32'(cnt_s), 32'd1);
    chk("mid_busy", 32'(busy_s), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_tx", 32'(tx_s), 32'd1);
    chk("arst_busy", 32'(busy_s), 32'd0);
    chk("arst_count", 32'(cnt_s), 32'd0);
    chk("arst_ready", 32'(rdy_s), 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      chk("post_reset_tx", 32'(tx_s), 32'd1);
      chk("post_reset_busy", 32'(busy_s), 32'd0);
    end

    // CTS raised during data bit 3: frame completes, queued bytes held until CTS returns
    q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      push(b);
    end
    wait_start("cts", 10);
    check_frame(q[0], PARITY_NONE, 1, CPB + 3 * CPB + 2);
    for (int i = 0; i < 40; i++) begin
      chk("cts_hold_tx", 32'(tx_s), 32'd1);
      chk("cts_hold_busy", 32'(busy_s), 32'd0);
      @(negedge CLK);
    end
    chk("cts_hold_count", 32'(cnt_s), 32'd2);
    cts_n = 1'b0;
    wait_start("cts_resume", 10);
    chk("cts_resume_latency_ok", 32'(last_wait <= 5), 32'd1);
    check_frame(q[1], PARITY_NONE, 1, -1);
    check_frame(q[2], PARITY_NONE, 1, -1);
    expect_idle("cts_resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
